// File: rtl/circuit_vector_driver_pkg.sv
// Shared types and constants for the circuit vector driver: state encoding,
// MISR polynomial and the vector-width to byte-count helper.
package circuit_vector_driver_pkg;

  localparam int unsigned DefaultVecW = 80;

  localparam logic [15:0] SIG_POLY = 16'h1021;

  // Legacy-compatible state encoding kept as plain constants.
  typedef logic [1:0] state_t;
  localparam state_t StLoad   = 2'd0;
  localparam state_t StSettle = 2'd1;
  localparam state_t StResp   = 2'd2;

  function automatic int unsigned nbytes(input int unsigned vec_w);
    return (vec_w + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/circuit_vector_driver_if.sv
// Byte-stream input and result handshake bundle between a host/testbench
// (master) and the circuit vector driver (slave).
interface circuit_vector_driver_if;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        res_valid;
  logic        res_ready;
  logic        res_f;
  logic [15:0] res_idx;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_f, res_idx
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_f, res_idx
  );

endinterface

// File: rtl/sig_misr16.sv
// 16-bit serial-input MISR used to compress the stream of sampled responses.
module sig_misr16
  import circuit_vector_driver_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        din,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = {state_q[14:0], 1'b0} ^ (state_q[15] ? SIG_POLY : 16'h0000) ^ {15'b0, din};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 16'h0000;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/circuit_vector_driver.sv
// Loads an input vector byte-by-byte, applies it atomically to the circuit, waits
// SETTLE cycles, samples f and returns it. Optional signature: CIRCUIT_VECTOR_DRIVER_SIG_EN.
module circuit_vector_driver
  import circuit_vector_driver_pkg::*;
#(
  parameter int unsigned VEC_W  = DefaultVecW,
  parameter int unsigned SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  circuit_vector_driver_if.slave bus,
  output logic [VEC_W-1:0]       a_out,
  input  logic                   f_in
`ifdef CIRCUIT_VECTOR_DRIVER_SIG_EN
  ,
  output logic [15:0]            sig
`endif
);

  localparam int unsigned NBYTES = nbytes(VEC_W);
  localparam int unsigned SW     = NBYTES * 8;
  localparam int unsigned BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [BW-1:0] LastByte   = BW'(NBYTES - 1);
  localparam logic [CW-1:0] SettleLast = CW'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     shadow_q, shadow_d;
  logic [VEC_W-1:0]  a_q, a_d;
  logic              res_f_q, res_f_d;
  logic [15:0]       res_idx_q, res_idx_d;
  logic              accept, hs;

  // Handshake outputs are gated by rst so nothing is offered during reset.
  assign bus.in_ready  = (state_q == StLoad) & ~rst;
  assign bus.res_valid = (state_q == StResp) & ~rst;
  assign bus.res_f     = res_f_q;
  assign bus.res_idx   = res_idx_q;
  assign a_out         = a_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign hs     = bus.res_valid & bus.res_ready;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    a_d        = a_q;
    res_f_d    = res_f_q;
    res_idx_d  = res_idx_q;
    case (state_q)
      StLoad: begin
        if (accept) begin
          shadow_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
          if (byte_cnt_q == LastByte) begin
            // Whole vector applied at once; upper pad bits of the last byte drop out.
            a_d        = shadow_d[VEC_W-1:0];
            byte_cnt_d = '0;
            cnt_d      = '0;
            state_d    = StSettle;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SettleLast) begin
          res_f_d = f_in;
          state_d = StResp;
        end
      end
      StResp: begin
        if (hs) begin
          res_idx_d = res_idx_q + 16'd1;
          state_d   = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      byte_cnt_q <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      a_q        <= '0;
      res_f_q    <= 1'b0;
      res_idx_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      a_q        <= a_d;
      res_f_q    <= res_f_d;
      res_idx_q  <= res_idx_d;
    end
  end

`ifdef CIRCUIT_VECTOR_DRIVER_SIG_EN
  sig_misr16 u_misr (
    .clk   (clk),
    .rst   (rst),
    .en    (hs),
    .din   (res_f_q),
    .state (sig)
  );
`endif

endmodule

// File: tb/tb_circuit_vector_driver.sv
// Bench for circuit_vector_driver: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a timestamp-based behavioural model.
module tb_circuit_vector_driver;

  localparam int unsigned VEC_W  = 80;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned NBYTES = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             f_in;
  logic [VEC_W-1:0] a_out;
`ifdef CIRCUIT_VECTOR_DRIVER_SIG_EN
  logic [15:0]      sig;
`endif

  always #5 clk = ~clk;

  circuit_vector_driver_if bus ();

  circuit_vector_driver #(
    .VEC_W  (VEC_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .a_out (a_out),
    .f_in  (f_in)
`ifdef CIRCUIT_VECTOR_DRIVER_SIG_EN
    ,
    .sig   (sig)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: bytes gathered so far, applied vector, and the cycle its last byte landed.
  logic [7:0]       mq[$];
  logic [VEC_W-1:0] m_a     = '0;
  bit               m_fl    = 1'b0;
  int               m_tf    = 0;
  logic             m_f     = 1'b0;
  logic [15:0]      m_idx   = 16'd0;
  logic [15:0]      m_sig   = 16'd0;
  bit               m_known = 1'b0;

  task automatic chkw(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chkw(name, 80'(act), 80'(exp));
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    chkw(name, 80'(act), 80'(exp));
  endtask

  function automatic logic exp_ready();
    return !rst && !m_fl;
  endfunction

  function automatic logic exp_valid();
    return !rst && m_fl && (cyc > m_tf + int'(SETTLE));
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic b);
    return (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
  endfunction

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic rr,
                       input logic f);
    rst           = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.res_ready = rr;
    f_in          = f;
  endtask

  task automatic sample();
    #1;
    if (m_known) begin
      chk1("in_ready", bus.in_ready, exp_ready());
      chk1("res_valid", bus.res_valid, exp_valid());
      chkw("a_out", a_out, m_a);
      chk1("res_f", bus.res_f, m_f);
      chk16("res_idx", bus.res_idx, m_idx);
`ifdef CIRCUIT_VECTOR_DRIVER_SIG_EN
      chk16("sig", sig, m_sig);
`endif
    end
  endtask

  task automatic adv();
    logic [NBYTES*8-1:0] pv;
    if (rst) begin
      mq.delete();
      m_a     = '0;
      m_fl    = 1'b0;
      m_f     = 1'b0;
      m_idx   = 16'd0;
      m_sig   = 16'd0;
      m_known = 1'b1;
    end else begin
      if (m_fl && cyc == m_tf + int'(SETTLE)) m_f = f_in;
      if (exp_valid() && bus.res_ready) begin
        m_sig = misr(m_sig, m_f);
        m_idx = m_idx + 16'd1;
        m_fl  = 1'b0;
      end else if (exp_ready() && bus.in_valid) begin
        mq.push_back(bus.in_data);
        if (mq.size() == int'(NBYTES)) begin
          pv = '0;
          foreach (mq[i]) pv[8*i +: 8] = mq[i];
          m_a  = pv[VEC_W-1:0];
          m_fl = 1'b1;
          m_tf = cyc;
          mq.delete();
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic rr,
                      input logic f);
    drive(r, v, d, rr, f);
    sample();
    adv();
  endtask

  // Streams one vector back-to-back, shapes f_in around the sample edge, checks the result.
  task automatic send_vec(input logic [VEC_W-1:0] v, input logic fpre, input logic fpost,
                          input logic exp_f, input logic [15:0] exp_idx, input bit do_hs);
    for (int i = 0; i < int'(NBYTES); i++) step(1'b0, 1'b1, v[8*i +: 8], 1'b0, fpre);
    chkw("vec_applied", a_out, v);
    step(1'b0, 1'b0, 8'h00, 1'b0, fpre);
    drive(1'b0, 1'b0, 8'h00, 1'b0, fpost);
    sample();
    chk1("res_valid_early", bus.res_valid, 1'b0);
    adv();
    drive(1'b0, 1'b0, 8'h00, 1'b0, fpost);
    sample();
    chk1("res_valid_rise", bus.res_valid, 1'b1);
    chk1("res_f_lit", bus.res_f, exp_f);
    chk16("res_idx_lit", bus.res_idx, exp_idx);
    adv();
    if (do_hs) step(1'b0, 1'b0, 8'h00, 1'b1, fpost);
  endtask

  initial begin
    logic       v;
    logic [7:0] d;
    logic       r;
    bit         acc;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);

    // Reset held two cycles, then ready on the first cycle after release.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    sample();
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chkw("rst_a_out", a_out, 80'h0);
    chk1("rst_res_valid", bus.res_valid, 1'b0);
    chk16("rst_res_idx", bus.res_idx, 16'h0000);
    adv();

    // Back-to-back load with f tied high, then backpressure with a pending byte.
    send_vec(80'h0A090807060504030201, 1'b1, 1'b1, 1'b1, 16'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
      sample();
      chk1("bp_in_ready", bus.in_ready, 1'b0);
      chk1("bp_res_valid", bus.res_valid, 1'b1);
      chk1("bp_res_f", bus.res_f, 1'b1);
      adv();
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Sample edge: f changes between T+1 and T+2.
    send_vec(80'h112233445566778899AA, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1);
    send_vec(80'hDEADBEEFCAFEF00D1234, 1'b1, 1'b0, 1'b0, 16'd2, 1'b1);

    // Reset in the middle of a vector discards the partial bytes.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    send_vec({VEC_W{1'b1}}, 1'b1, 1'b1, 1'b1, 16'd0, 1'b1);

`ifdef CIRCUIT_VECTOR_DRIVER_SIG_EN
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    send_vec(80'h1, 1'b1, 1'b1, 1'b1, 16'd0, 1'b1);
    chk16("sig_1", sig, 16'h0001);
    send_vec(80'h2, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1);
    chk16("sig_2", sig, 16'h0002);
    send_vec(80'h3, 1'b1, 1'b1, 1'b1, 16'd2, 1'b1);
    chk16("sig_3", sig, 16'h0005);
`endif

    // Randomized traffic; producer holds a byte until it is taken.
    v   = 1'b0;
    d   = 8'h00;
    acc = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      r = ($urandom_range(0, 299) == 0);
      if (!v || acc) begin
        v = ($urandom_range(0, 9) < 7);
        d = 8'($urandom);
      end
      drive(r, v, d, 1'($urandom_range(0, 1)), 1'($urandom));
      sample();
      acc = exp_ready() && v;
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/circuit_vector_driver.md
# circuit_vector_driver

Sequential stimulus driver and response capture for the flat combinational benchmark circuits (80 inputs `a0..a79`, single output `f`). Accepts an input vector as a byte stream, applies it atomically to the circuit's inputs, holds it for a fixed settle time, samples `f`, and returns the result over a valid/ready handshake. It sits between the testbench or host link and one instance of a generated circuit.

## Interface
- `VEC_W`, 80: circuit input count; width of `a_out`.
- `SETTLE`, 2: cycles the new vector is held before `f_in` is sampled; legal range ≥1.
- `NBYTES`, derived as ceil(VEC_W/8), 10 by default: bytes per vector. Not overridable.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte available.
- `in_ready`  out  1  driver accepts a byte.
- `in_data`  in  8  vector byte; the first byte maps to `a[7:0]`, little-endian.
- `a_out`  out  VEC_W  drives circuit inputs; bit i connects to `a<i>`.
- `f_in`  in  1  circuit output `f`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_f`  out  1  sampled `f`.
- `res_idx`  out  16  index of the vector this result belongs to.
- `sig`  out  16  response signature; present only with `CIRCUIT_VECTOR_DRIVER_SIG_EN`.

## Operation
- FSM states: LOAD, SETTLE, RESP.
- **LOAD**
  - `in_ready`=1.
  - Each accepted byte (`in_valid`&`in_ready`) is written into the shadow register at byte slot `byte_cnt`, then `byte_cnt` increments.
  - If VEC_W is not a multiple of 8, the unused upper bits of the final byte are ignored.
  - On the NBYTES-th byte, the shadow register is copied to `a_out`, `byte_cnt` is cleared, the settle counter is cleared, and the FSM goes to SETTLE.
- **SETTLE**
  - `in_ready`=0. The counter increments every cycle.
  - On the cycle the counter reaches SETTLE−1, `f_in` is captured into `res_f` and the FSM goes to RESP.
- **RESP**
  - `res_valid`=1 and `in_ready`=0.
  - `res_f` and `res_idx` are stable while `res_valid` is high.
  - On `res_valid`&`res_ready`: `res_idx` increments (wraps 0xFFFF→0), the signature updates, and the FSM returns to LOAD.
- `a_out` holds the last applied vector until the next complete vector arrives. It is never partially updated.
- Reset values:
  - `a_out`=0, `res_valid`=0, `res_f`=0, `res_idx`=0, `sig`=0.
  - `in_ready`=0 while `rst` is high; state LOAD and `byte_cnt`=0 after reset.
- Reset mid-vector discards the partial shadow contents and the byte count. Reset in SETTLE or RESP drops the pending result.

## Timing
- If the final byte is accepted in cycle T:
  - `a_out` shows the new vector from T+1.
  - `f_in` is sampled at the edge ending cycle T+SETTLE.
  - `res_valid` rises in T+SETTLE+1.
- If `res_ready` is high when `res_valid` rises, the handshake completes that cycle and `in_ready`=1 from the next cycle.
- Minimum vector period: NBYTES+SETTLE+1 cycles.
- `in_valid` while `in_ready`=0 is ignored. The producer must hold the byte until it is accepted.
- `res_valid` never drops without a handshake, except on reset.

## Configuration
- `CIRCUIT_VECTOR_DRIVER_SIG_EN` defined:
  - Adds the `sig` port and a 16-bit MISR.
  - Update on each result handshake: sig ← (sig<<1) ^ (sig[15] ? 16'h1021 : 0) ^ {15'b0, res_f}.
  - Reset value 0.
- Macro undefined: no `sig` port, no MISR logic. All other behaviour is identical.

## Structure
- Package `circuit_vector_driver_pkg` holds:
  - the state enum (LOAD/SETTLE/RESP);
  - the `SIG_POLY` constant 16'h1021;
  - the `nbytes(vec_w)` function;
  - the default VEC_W.
- One sub-module, `sig_misr16`: clock, reset, enable, data bit, 16-bit state. It is instantiated only under the macro.

## Test plan
- Reset check: after `rst` is held 2 cycles then released, `a_out`=0, `res_valid`=0, `res_idx`=0, and `in_ready`=1 on the first cycle after release.
- Back-to-back load, SETTLE=2, `f_in` tied 1, bytes 0x01..0x0A sent continuously, final byte accepted in cycle T:
  - `a_out`=80'h0A090807060504030201 from T+1;
  - `res_valid` at T+3 with `res_f`=1 and `res_idx`=0.
- Sample edge: `f_in`=0 through cycle T+1 and 1 from T+2 → `res_f`=1; `f_in`=1 through T+1 and 0 from T+2 → `res_f`=0.
- Backpressure: `res_ready` held low 5 cycles with `in_valid` high → `res_valid` and `res_f` held, `in_ready`=0, no bytes consumed. After the handshake, the next result carries `res_idx`=1.
- Reset after 4 bytes, then 10 bytes of 0xFF → `a_out`=all ones. No stale bytes appear.
- With `CIRCUIT_VECTOR_DRIVER_SIG_EN`: three results with `f`=1,0,1 → `sig` = 0x0001, 0x0002, 0x0005 after each handshake.
